// File: rtl/hamming_frame_decoder.sv
// rtl/hamming_frame_decoder.sv - serial multi-chunk Hamming SEC / SEC-DED frame decoder
// One chunk is decoded per cycle; results are held until the consumer takes the frame.
module hamming_frame_decoder #(
   parameter int DATA_W  = 16,
   parameter int N_CHUNK = 4,
   parameter int SECDED  = 1,
   parameter int CNT_W   = 16,
   // smallest r with 2^r >= DATA_W + r + 1
   localparam int R = (DATA_W <= 1)  ? 2 :
                      (DATA_W <= 4)  ? 3 :
                      (DATA_W <= 11) ? 4 :
                      (DATA_W <= 26) ? 5 :
                      (DATA_W <= 57) ? 6 :
                      (DATA_W <= 120) ? 7 : 8,
   localparam int CW_W = DATA_W + R + SECDED
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_CHUNK*CW_W-1:0]     in_frame,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_CHUNK*DATA_W-1:0]   out_data,
   output logic [N_CHUNK-1:0]          out_corr,
   output logic [N_CHUNK-1:0]          out_uncorr,
   output logic [CNT_W-1:0]            corr_cnt,
   output logic [CNT_W-1:0]            uncorr_cnt,
   input  logic                        cnt_clr
);

   localparam int HPOS  = DATA_W + R;
   localparam int IDX_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

   state_t                     state;
   logic [IDX_W-1:0]           idx;
   logic [N_CHUNK*CW_W-1:0]    frame_q;

   logic [CW_W-1:0]            cw;
   logic [CW_W-1:0]            fixed;
   logic [R-1:0]               syn;
   logic                       par;
   logic                       do_flip;
   logic                       dec_corr;
   logic                       dec_uncorr;
   logic [DATA_W-1:0]          dec_data;

   assign in_ready = (state == IDLE);

   always_comb begin
      int k;
      cw         = frame_q[int'(idx)*CW_W +: CW_W];
      syn        = '0;
      par        = ^cw;
      do_flip    = 1'b0;
      dec_corr   = 1'b0;
      dec_uncorr = 1'b0;
      dec_data   = '0;
      for (int p = 1; p <= HPOS; p++) begin
         if (cw[p-1]) syn = syn ^ R'(p);
      end
      if (SECDED != 0) begin
         if (syn == '0) begin
            // only the overall parity bit itself can be wrong here
            dec_corr = par;
         end else if (par) begin
            if (int'(syn) > HPOS) dec_uncorr = 1'b1;
            else begin
               do_flip  = 1'b1;
               dec_corr = 1'b1;
            end
         end else begin
            dec_uncorr = 1'b1;
         end
      end else if (syn != '0) begin
         if (int'(syn) > HPOS) dec_uncorr = 1'b1;
         else begin
            do_flip  = 1'b1;
            dec_corr = 1'b1;
         end
      end
      fixed = cw;
      for (int p = 1; p <= HPOS; p++) begin
         if (do_flip && (R'(p) == syn)) fixed[p-1] = ~fixed[p-1];
      end
      k = 0;
      for (int p = 1; p <= HPOS; p++) begin
         if ((p & (p - 1)) != 0) begin
            dec_data[k] = fixed[p-1];
            k = k + 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         frame_q    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_corr   <= '0;
         out_uncorr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  frame_q    <= in_frame;
                  out_corr   <= '0;
                  out_uncorr <= '0;
                  idx        <= '0;
                  state      <= DECODE;
               end
            end
            DECODE: begin
               out_data[int'(idx)*DATA_W +: DATA_W] <= dec_data;
               out_corr[idx]   <= dec_corr;
               out_uncorr[idx] <= dec_uncorr;
               if (idx == IDX_W'(N_CHUNK - 1)) begin
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (state == DECODE) begin
         if (dec_corr && (corr_cnt != {CNT_W{1'b1}}))
            corr_cnt <= corr_cnt + CNT_W'(1);
         if (dec_uncorr && (uncorr_cnt != {CNT_W{1'b1}}))
            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/hamming_frame_decoder.md
Name: hamming_frame_decoder

Overview:
- Parametrised multi-chunk Hamming decoder for the receive path, sitting between the link input and the PRESENT decrypt core.
- Takes one frame of N_CHUNK codewords and decodes it serially, one chunk per cycle.
- Corrects single-bit errors. In SECDED mode it also detects double-bit errors.
- Reports per-chunk correction and uncorrectable flags, keeps saturating error counters, and handshakes on both sides with valid/ready.

Parameters:
- DATA_W, 16: data bits per chunk.
- N_CHUNK, 4: chunks per frame.
- SECDED, 1: 1 adds an overall parity bit (SEC-DED); 0 is plain SEC.
- CNT_W, 16: error counter width.
- Derived R: smallest r with 2^r >= DATA_W+r+1 (5 for DATA_W=16).
- Derived CW_W: DATA_W+R+SECDED.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  frame present on in_frame.
- in_ready  out  1  decoder can accept a frame.
- in_frame  in  N_CHUNK*CW_W  codewords, chunk 0 in LSBs.
- out_valid  out  1  decoded frame available.
- out_ready  in  1  consumer accepts the frame.
- out_data  out  N_CHUNK*DATA_W  corrected data, chunk 0 in LSBs.
- out_corr  out  N_CHUNK  per-chunk single error corrected.
- out_uncorr  out  N_CHUNK  per-chunk uncorrectable error.
- corr_cnt  out  CNT_W  saturating total of corrected chunks.
- uncorr_cnt  out  CNT_W  saturating total of uncorrectable chunks.
- cnt_clr  in  1  synchronous clear of both counters.

Behaviour:
- Codeword layout:
  - Hamming position p (1..DATA_W+R) sits at chunk bit p-1.
  - Parity bits are at power-of-two positions.
  - Data bits fill the remaining positions in ascending order, data bit 0 at the lowest.
  - With SECDED=1, chunk bit CW_W-1 is the overall parity: even parity over all CW_W bits.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; chunk index = 0.
  - out_valid, out_data, out_corr, out_uncorr, corr_cnt, uncorr_cnt all = 0.
  - in_ready = 1, since it is combinational (state==IDLE).
- FSM IDLE:
  - in_valid && in_ready at an edge captures in_frame into a register, clears the flags and moves to DECODE.
- FSM DECODE:
  - Each cycle decodes chunk idx and writes its data/flag slice; idx increments.
  - After chunk N_CHUNK-1 the FSM moves to HOLD and sets out_valid.
  - Latency: out_valid is high N_CHUNK cycles after the accepting edge.
- FSM HOLD:
  - out_* stay stable while out_ready = 0.
  - out_valid && out_ready clears out_valid and returns to IDLE; a new frame can be accepted on the next edge.
  - out_data holds its last value until overwritten.
- Syndrome s (R bits) = XOR of the positions of all set bits; P = XOR of all CW_W bits.
- Decode rules, SECDED=1:
  - s=0, P=0: clean.
  - s≠0, P=1: flip position s, corr=1. If s > DATA_W+R: uncorr=1 and data passes raw.
  - s=0, P=1: overall parity bit error, corr=1, data unchanged.
  - s≠0, P=0: double error, uncorr=1, data passes raw (uncorrected).
- Decode rules, SECDED=0:
  - s=0: clean.
  - s in 1..DATA_W+R: flip position s, corr=1.
  - s > DATA_W+R: uncorr=1, data passes raw.
- Counters:
  - Incremented in the cycle each chunk decodes, saturating at 2^CNT_W-1.
  - cnt_clr wins over a simultaneous increment.
- rst_n low mid-DECODE aborts the frame. No partial output and no counter update follow.

Test Plan:
- Clean frame, encoded from 64'h0123_4567_89AB_CDEF, out_ready=1 -> out_valid exactly 4 cycles after accept; out_data=64'h0123_4567_89AB_CDEF; out_corr=out_uncorr=0; counters 0.
- Same frame with bits 0, 22, 44, 66 inverted (position 1 of every chunk) -> data restored; out_corr=4'b1111; corr_cnt=4.
- Chunk 2 with two data bits flipped, chunk 0 with bit 21 (overall parity) flipped -> out_uncorr=4'b0100 and chunk 2 raw; out_corr=4'b0001 and chunk 0 data intact; uncorr_cnt=1, corr_cnt=1.
- out_ready held 0 for 10 cycles, in_valid held high with a second frame -> out_* stable and in_ready=0 throughout; second frame accepted on the edge after the handshake; its out_valid follows 4 cycles later.
- rst_n pulsed low 2 cycles after accept -> all outputs 0 immediately; in_ready=1; counters 0; no out_valid.
- CNT_W=4, four frames each with 4 single errors -> corr_cnt saturates at 15. Then cnt_clr asserted during a decoding increment -> corr_cnt=0.
